shift_register: RTL and testbench

- N-bit clocked register with synchronous reset, parallel load, and serial shift in either direction.
- Serves as the program-counter state register of the RISC-V CPU.
- Each cycle it either loads a parallel word (normal PC update) or shifts one bit with a serial input bit.
- Optional build: a carry-lookahead "+STEP" incrementer, so the PC loop can close locally.

---
 rtl/shift_register_pkg.sv | 11 +
 rtl/shift_register_if.sv | 39 +++
 rtl/shift_register_cla_adder.sv | 65 ++++++
 rtl/shift_register.sv | 47 ++++
 tb/tb_shift_register.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/shift_register_pkg.sv
// Shared constants for the PC shift register and its datapath helpers.
package sr_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned PC_STEP = 4;

  // Shift direction encodings
  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

endpackage : sr_pkg

// File: rtl/shift_register_if.sv
// Control/data bundle of the shift register; q_next_inc exists only with SR_INCR_EN.
interface shift_register_if
  import sr_pkg::*;
#(
  parameter int unsigned N = XLEN
);

  logic         serial_in;
  logic         direction;
  logic         shift_en;
  logic [N-1:0] par_in;
  logic [N-1:0] q;
`ifdef SR_INCR_EN
  logic [N-1:0] q_next_inc;
`endif

`ifdef SR_INCR_EN
  modport master (
    output serial_in, direction, shift_en, par_in,
    input  q, q_next_inc
  );

  modport slave (
    input  serial_in, direction, shift_en, par_in,
    output q, q_next_inc
  );
`else
  modport master (
    output serial_in, direction, shift_en, par_in,
    input  q
  );

  modport slave (
    input  serial_in, direction, shift_en, par_in,
    output q
  );
`endif

endinterface : shift_register_if

// File: rtl/shift_register_cla_adder.sv
// N-bit carry-lookahead adder: 4-bit groups with generate/propagate terms,
// group carries resolved by a lookahead chain; the top group may be narrower.
module cla_adder #(
  parameter int unsigned N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int unsigned NG = (N + 3) / 4;

  logic [N-1:0]  g;
  logic [N-1:0]  p;
  logic [N-1:0]  c;
  logic [NG-1:0] grp_g;
  logic [NG-1:0] grp_p;
  logic [NG:0]   grp_c;

  // Bit-level generate/propagate
  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate, clipped at bit N-1 for the top group
  always_comb begin
    grp_g = '0;
    grp_p = '0;
    for (int k = 0; k < int'(NG); k++) begin
      grp_g[k] = 1'b0;
      grp_p[k] = 1'b1;
      for (int j = 0; j < 4; j++) begin
        if (4 * k + j < int'(N)) begin
          grp_g[k] = g[4*k+j] | (p[4*k+j] & grp_g[k]);
          grp_p[k] = grp_p[k] & p[4*k+j];
        end
      end
    end
  end

  // Lookahead unit producing the carry into each group
  always_comb begin
    grp_c    = '0;
    grp_c[0] = 1'b0;
    for (int k = 0; k < int'(NG); k++) begin
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
    end
  end

  // Carries inside each group start from the lookahead group carry
  always_comb begin
    c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (i % 4 == 0) begin
        c[i] = grp_c[i/4];
      end else begin
        c[i] = g[i-1] | (p[i-1] & c[i-1]);
      end
    end
  end

  assign sum  = p ^ c;
  assign cout = grp_c[NG];

endmodule : cla_adder

// File: rtl/shift_register.sv
// PC state register: synchronous reset, parallel load, bidirectional serial shift.
// Build option SR_INCR_EN adds a combinational q + STEP output (q_next_inc).
module shift_register
  import sr_pkg::*;
#(
  parameter int unsigned N    = XLEN,
  parameter int unsigned STEP = PC_STEP
) (
  input logic             clk,
  input logic             reset,
  shift_register_if.slave sr
);

  logic [N-1:0] q_r;

  // Register update: reset beats shift, shift beats load
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= '0;
    end else if (sr.shift_en) begin
      if (sr.direction == SHIFT_LEFT) begin
        q_r <= {q_r[N-2:0], sr.serial_in};
      end else begin
        q_r <= {sr.serial_in, q_r[N-1:1]};
      end
    end else begin
      q_r <= sr.par_in;
    end
  end

  assign sr.q = q_r;

`ifdef SR_INCR_EN
  logic inc_cout_unused;

  // Local PC incrementer, carry-out dropped so the result wraps modulo 2^N
  cla_adder #(
    .N (N)
  ) u_inc (
    .a    (q_r),
    .b    (N'(STEP)),
    .sum  (sr.q_next_inc),
    .cout (inc_cout_unused)
  );
`endif

endmodule : shift_register

// File: tb/tb_shift_register.sv
// Scoreboard bench for shift_register (N=64, STEP=4); PC-loop and wrap
// sequences run only when SR_INCR_EN is defined.
module tb_shift_register;

  localparam int unsigned N = 64;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] model_q;

  shift_register_if #(.N(N)) sr_bus ();

  shift_register #(
    .N    (N),
    .STEP (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sr    (sr_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Drive one cycle, queue the expected q, compare after the edge
  task automatic step(input string tag, input logic r, input logic se, input logic d,
                      input logic si, input logic [N-1:0] pin, input logic [N-1:0] want);
    reset            = r;
    sr_bus.shift_en  = se;
    sr_bus.direction = d;
    sr_bus.serial_in = si;
    sr_bus.par_in    = pin;
    exp_q.push_back(want);
    model_q = want;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      check(tag, sr_bus.q, exp_q.pop_front());
    end
  endtask

  function automatic logic [N-1:0] ref_next(input logic [N-1:0] cur, input logic r,
                                           input logic se, input logic d, input logic si,
                                           input logic [N-1:0] pin);
    logic [N-1:0] n;
    if (r) n = '0;
    else if (!se) n = pin;
    else if (!d) n = (cur << 1) | N'(si);
    else n = (cur >> 1) | ({si, {(N-1){1'b0}}});
    return n;
  endfunction

  initial begin
    total   = 0;
    bad     = 0;
    model_q = '0;
    reset   = 1'b1;
    sr_bus.shift_en  = 1'b1;
    sr_bus.direction = 1'b0;
    sr_bus.serial_in = 1'b1;
    sr_bus.par_in    = 64'hDEAD_BEEF;
    #2;

    // Reset wins over shift for two edges
    step("rst0", 1'b1, 1'b1, 1'b0, 1'b1, 64'hDEAD_BEEF, 64'h0);
    step("rst1", 1'b1, 1'b1, 1'b0, 1'b1, 64'hDEAD_BEEF, 64'h0);

    // Left shift, interrupted by reset at q=3
    step("shl1", 1'b0, 1'b1, 1'b0, 1'b1, 64'h0, 64'h1);
    step("shl3", 1'b0, 1'b1, 1'b0, 1'b1, 64'h0, 64'h3);
    step("rst_mid", 1'b1, 1'b1, 1'b0, 1'b1, 64'h0, 64'h0);
    step("resume1", 1'b0, 1'b1, 1'b0, 1'b1, 64'h0, 64'h1);
    step("shl3b", 1'b0, 1'b1, 1'b0, 1'b1, 64'h0, 64'h3);
    step("shl7", 1'b0, 1'b1, 1'b0, 1'b1, 64'h0, 64'h7);
    step("shl14", 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'hE);

    // Right shift drops the old LSB
    step("ld_8001", 1'b0, 1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);
    step("shr_4000", 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 64'h4000_0000_0000_0000);
    step("shr_A000", 1'b0, 1'b1, 1'b1, 1'b1, 64'h0, 64'hA000_0000_0000_0000);

    // Left shift drops the old MSB; right shift fills from serial_in
    step("ld_ones", 1'b0, 1'b0, 1'b1, 1'b1, {N{1'b1}}, {N{1'b1}});
    step("shl_drop", 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE);
    step("shr_fill", 1'b0, 1'b1, 1'b1, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    step("shr_zero", 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF);

    // Hold by reloading q; load ignores direction and serial_in
    step("ld_5a", 1'b0, 1'b0, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    step("hold", 1'b0, 1'b0, 1'b0, 1'b0, sr_bus.q, 64'h0123_4567_89AB_CDEF);

`ifdef SR_INCR_EN
    // PC loop closed through q_next_inc
    step("pc_rst", 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    check("inc_at0", sr_bus.q_next_inc, 64'd4);
    for (int i = 1; i <= 5; i++) begin
      step("pc_loop", 1'b0, 1'b0, 1'b0, 1'b0, sr_bus.q_next_inc, 64'(4 * i));
      check("inc_loop", sr_bus.q_next_inc, 64'(4 * i + 4));
    end
    step("ld_wrap", 1'b0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
    check("inc_wrap", sr_bus.q_next_inc, 64'h0);
    step("pc_wrap", 1'b0, 1'b0, 1'b0, 1'b0, sr_bus.q_next_inc, 64'h0);
    step("ld_carry", 1'b0, 1'b0, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFE, 64'h0000_0000_FFFF_FFFE);
    check("inc_carry", sr_bus.q_next_inc, 64'h0000_0001_0000_0002);
`endif

    // Random mix of reset, shift and load against a reference model
    for (int i = 0; i < 40; i++) begin
      logic         r;
      logic         se;
      logic         d;
      logic         si;
      logic [N-1:0] pin;
      r   = ($urandom_range(0, 9) == 0);
      se  = 1'($urandom_range(0, 1));
      d   = 1'($urandom_range(0, 1));
      si  = 1'($urandom_range(0, 1));
      pin = {$urandom(), $urandom()};
      step("rand", r, se, d, si, pin, ref_next(model_q, r, se, d, si, pin));
`ifdef SR_INCR_EN
      check("rand_inc", sr_bus.q_next_inc, model_q + 64'd4);
`endif
    end

    if (exp_q.size() != 0) begin
      check("sb_left", 64'(exp_q.size()), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_shift_register
